// File: rtl/qinterlace.sv
// Two-input transaction-granular interleaver: merges two {eot, data} queue streams
// into one registered {eot, ctrl, data} stream, ctrl naming the source channel.
//
// state  | meaning
// IDLE   | no transaction open; round-robin between valid channels using prio
// LOCKED | mid-transaction on lock_ch; the other channel is not served
module qinterlace #(
  parameter int W_DIN = 16,
  parameter int LVL   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W_DIN+LVL-1:0]   din0_data,
  input  logic                   din0_valid,
  output logic                   din0_ready,
  input  logic [W_DIN+LVL-1:0]   din1_data,
  input  logic                   din1_valid,
  output logic                   din1_ready,
  output logic [W_DIN+LVL:0]     dout_data,
  output logic                   dout_valid,
  input  logic                   dout_ready
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_e;

  lock_e                 lock_q, lock_d;
  logic                  lock_ch_q, lock_ch_d;
  logic                  prio_q, prio_d;
  logic                  out_valid_q, out_valid_d;
  logic [W_DIN+LVL:0]    out_data_q, out_data_d;

  logic                  load;
  logic                  sel_any;
  logic                  sel_ch;
  logic                  sel_valid;
  logic                  in_hs;
  logic                  out_hs;
  logic [LVL-1:0]        sel_eot;
  logic [W_DIN-1:0]      sel_dat;

  // Grant logic; a locked channel keeps its grant even while its valid is low.
  always_comb begin
    load    = !out_valid_q || dout_ready;
    sel_any = 1'b0;
    sel_ch  = 1'b0;
    if (lock_q == LOCKED) begin
      sel_any = 1'b1;
      sel_ch  = lock_ch_q;
    end else if (din0_valid && din1_valid) begin
      sel_any = 1'b1;
      sel_ch  = prio_q;
    end else if (din1_valid) begin
      sel_any = 1'b1;
      sel_ch  = 1'b1;
    end else if (din0_valid) begin
      sel_any = 1'b1;
    end
    sel_valid  = sel_ch ? din1_valid : din0_valid;
    din0_ready = sel_any && load && !sel_ch;
    din1_ready = sel_any && load && sel_ch;
    in_hs      = sel_any && load && sel_valid;
    out_hs     = out_valid_q && dout_ready;
    {sel_eot, sel_dat} = sel_ch ? din1_data : din0_data;
  end

  always_comb begin
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    prio_d      = prio_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (in_hs) begin
      out_data_d  = {sel_eot, sel_ch, sel_dat};
      out_valid_d = 1'b1;
      if (&sel_eot) begin
        lock_d = IDLE;
        prio_d = !sel_ch;
      end else begin
        lock_d    = LOCKED;
        lock_ch_d = sel_ch;
      end
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q      <= IDLE;
      lock_ch_q   <= 1'b0;
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign dout_data  = out_data_q;
  assign dout_valid = out_valid_q;

endmodule

// File: tb/tb_qinterlace.sv
// Bench for qinterlace: directed vector table, hand-written corner sequences and a
// randomized backpressure run checked against per-channel source queues.
module tb_qinterlace;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // LVL=1, W_DIN=16 instance
  logic [16:0] d0_data, d1_data;
  logic        d0_valid, d0_ready, d1_valid, d1_ready;
  logic [17:0] o_data;
  logic        o_valid, o_ready;

  // LVL=2, W_DIN=8 instance
  logic [9:0]  e0_data, e1_data;
  logic        e0_valid, e0_ready, e1_valid, e1_ready;
  logic [10:0] p_data;
  logic        p_valid, p_ready;

  qinterlace #(.W_DIN(16), .LVL(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .din0_data(d0_data), .din0_valid(d0_valid), .din0_ready(d0_ready),
    .din1_data(d1_data), .din1_valid(d1_valid), .din1_ready(d1_ready),
    .dout_data(o_data), .dout_valid(o_valid), .dout_ready(o_ready)
  );

  qinterlace #(.W_DIN(8), .LVL(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .din0_data(e0_data), .din0_valid(e0_valid), .din0_ready(e0_ready),
    .din1_data(e1_data), .din1_valid(e1_valid), .din1_ready(e1_ready),
    .dout_data(p_data), .dout_valid(p_valid), .dout_ready(p_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    d0_valid = 1'b0; d1_valid = 1'b0; e0_valid = 1'b0; e1_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst_before;
    logic        v0;
    logic [16:0] d0;
    logic        v1;
    logic [16:0] d1;
    logic        rdy;
    logic        er0;
    logic        er1;
    logic        eov;
    logic [17:0] eod;
  } vec_t;

  vec_t vecs[12];

  logic [16:0] src[2][200];
  int          sidx[2];
  int          ridx[2];
  logic [9:0]  l2_in[3];
  logic [10:0] l2_exp[3];
  logic        hs0, hs1, ohs, prev_stall, in_txn, txn_ch;
  logic [17:0] cur, prev_data;
  int          ch, cyc;

  initial begin
    d0_data = '0; d1_data = '0; e0_data = '0; e1_data = '0;
    d0_valid = 1'b0; d1_valid = 1'b0; e0_valid = 1'b0; e1_valid = 1'b0;
    o_ready = 1'b1; p_ready = 1'b1;

    // Contention: din0 3-item transaction wins on prio=0, din1 follows with no bubble.
    vecs[0]  = '{1'b1, 1'b1, 17'h00011, 1'b1, 17'h000A1, 1'b1, 1'b1, 1'b0, 1'b1, 18'h00011};
    vecs[1]  = '{1'b0, 1'b1, 17'h00012, 1'b1, 17'h000A1, 1'b1, 1'b1, 1'b0, 1'b1, 18'h00012};
    vecs[2]  = '{1'b0, 1'b1, 17'h10013, 1'b1, 17'h000A1, 1'b1, 1'b1, 1'b0, 1'b1, 18'h20013};
    vecs[3]  = '{1'b0, 1'b0, 17'h00000, 1'b1, 17'h000A1, 1'b1, 1'b0, 1'b1, 1'b1, 18'h100A1};
    vecs[4]  = '{1'b0, 1'b0, 17'h00000, 1'b1, 17'h100A2, 1'b1, 1'b0, 1'b1, 1'b1, 18'h300A2};
    vecs[5]  = '{1'b0, 1'b0, 17'h00000, 1'b0, 17'h00000, 1'b1, 1'b0, 1'b0, 1'b0, 18'h300A2};
    // Round robin with single-item transactions.
    vecs[6]  = '{1'b1, 1'b1, 17'h10001, 1'b1, 17'h10081, 1'b1, 1'b1, 1'b0, 1'b1, 18'h20001};
    vecs[7]  = '{1'b0, 1'b1, 17'h10002, 1'b1, 17'h10081, 1'b1, 1'b0, 1'b1, 1'b1, 18'h30081};
    vecs[8]  = '{1'b0, 1'b1, 17'h10002, 1'b1, 17'h10082, 1'b1, 1'b1, 1'b0, 1'b1, 18'h20002};
    vecs[9]  = '{1'b0, 1'b1, 17'h10003, 1'b1, 17'h10082, 1'b1, 1'b0, 1'b1, 1'b1, 18'h30082};
    vecs[10] = '{1'b0, 1'b1, 17'h10003, 1'b1, 17'h10083, 1'b1, 1'b1, 1'b0, 1'b1, 18'h20003};
    vecs[11] = '{1'b0, 1'b0, 17'h00000, 1'b1, 17'h10083, 1'b1, 1'b0, 1'b1, 1'b1, 18'h30083};

    do_reset();
    check("reset dout_valid", 32'(o_valid), 32'h0);
    check("reset dout_data", 32'(o_data), 32'h0);
    check("reset din0_ready", 32'(d0_ready), 32'h0);
    check("reset din1_ready", 32'(d1_ready), 32'h0);
    check("reset lvl2 dout_valid", 32'(p_valid), 32'h0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst_before) do_reset();
      d0_valid = vecs[i].v0; d0_data = vecs[i].d0;
      d1_valid = vecs[i].v1; d1_data = vecs[i].d1;
      o_ready  = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("row%0d din0_ready", i), 32'(d0_ready), 32'(vecs[i].er0));
      check($sformatf("row%0d din1_ready", i), 32'(d1_ready), 32'(vecs[i].er1));
      @(posedge clk); #1;
      check($sformatf("row%0d dout_valid", i), 32'(o_valid), 32'(vecs[i].eov));
      check($sformatf("row%0d dout_data", i), 32'(o_data), 32'(vecs[i].eod));
    end

    // Lock with gap: din1 must not slip into din0's open transaction.
    do_reset();
    o_ready = 1'b1;
    d0_valid = 1'b1; d0_data = 17'h00001;
    d1_valid = 1'b1; d1_data = 17'h100B1;
    @(negedge clk);
    check("gap first din0_ready", 32'(d0_ready), 32'h1);
    @(posedge clk); #1;
    check("gap first dout", 32'(o_data), 32'h00001);
    d0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("gap%0d din1_ready", i), 32'(d1_ready), 32'h0);
      @(posedge clk); #1;
      check($sformatf("gap%0d dout_valid", i), 32'(o_valid), 32'h0);
    end
    d0_valid = 1'b1; d0_data = 17'h10002;
    @(negedge clk);
    check("gap last din1_ready", 32'(d1_ready), 32'h0);
    @(posedge clk); #1;
    check("gap last dout", 32'(o_data), 32'h20002);
    d0_valid = 1'b0;
    @(posedge clk); #1;
    check("gap then din1", 32'(o_data), 32'h300B1);
    d1_valid = 1'b0;

    // Reset while full, with prio=1 and a lock on din1 beforehand.
    do_reset();
    o_ready = 1'b1;
    d0_valid = 1'b1; d0_data = 17'h10044;
    @(posedge clk); #1;
    check("rf single item", 32'(o_data), 32'h20044);
    d0_valid = 1'b0;
    d1_valid = 1'b1; d1_data = 17'h00055;
    @(posedge clk); #1;
    check("rf overwrite valid", 32'(o_valid), 32'h1);
    check("rf overwrite data", 32'(o_data), 32'h10055);
    d1_data = 17'h10056; o_ready = 1'b0;
    @(negedge clk);
    check("rf stall din0_ready", 32'(d0_ready), 32'h0);
    check("rf stall din1_ready", 32'(d1_ready), 32'h0);
    @(posedge clk); #1;
    check("rf stall hold", 32'(o_data), 32'h10055);
    #2;
    rst = 1'b0;
    #1;
    check("rf async valid", 32'(o_valid), 32'h0);
    check("rf async data", 32'(o_data), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    o_ready = 1'b1;
    d0_valid = 1'b1; d0_data = 17'h10066;
    d1_valid = 1'b1; d1_data = 17'h10077;
    #1;
    check("rf restart din0_ready", 32'(d0_ready), 32'h1);
    check("rf restart din1_ready", 32'(d1_ready), 32'h0);
    @(posedge clk); #1;
    check("rf restart dout", 32'(o_data), 32'h20066);

    // LVL=2: lock held until eot == 2'b11, eot bits pass through.
    do_reset();
    l2_in[0] = 10'h110; l2_in[1] = 10'h111; l2_in[2] = 10'h312;
    l2_exp[0] = 11'h210; l2_exp[1] = 11'h211; l2_exp[2] = 11'h612;
    p_ready = 1'b1;
    e1_valid = 1'b1; e1_data = 10'h3C0;
    for (int i = 0; i < 3; i++) begin
      e0_valid = 1'b1; e0_data = l2_in[i];
      @(negedge clk);
      check($sformatf("lvl2 item%0d din1_ready", i), 32'(e1_ready), 32'h0);
      check($sformatf("lvl2 item%0d din0_ready", i), 32'(e0_ready), 32'h1);
      @(posedge clk); #1;
      check($sformatf("lvl2 item%0d dout", i), 32'(p_data), 32'(l2_exp[i]));
    end
    e0_valid = 1'b0;
    @(negedge clk);
    check("lvl2 din1 after eot ready", 32'(e1_ready), 32'h1);
    @(posedge clk); #1;
    check("lvl2 din1 after eot dout", 32'(p_data), 32'h7C0);
    e1_valid = 1'b0;

    // Randomized backpressure against per-channel source queues.
    for (int c = 0; c < 2; c++) begin
      sidx[c] = 0; ridx[c] = 0;
      for (int i = 0; i < 200; i++)
        src[c][i] = {(i == 199) || ($urandom % 4 == 0), 16'($urandom)};
    end
    do_reset();
    prev_stall = 1'b0; prev_data = '0; in_txn = 1'b0; txn_ch = 1'b0; cyc = 0;
    while ((ridx[0] < 200 || ridx[1] < 200) && cyc < 6000) begin
      if (!d0_valid && sidx[0] < 200 && $urandom % 10 < 7) begin
        d0_valid = 1'b1; d0_data = src[0][sidx[0]];
      end
      if (!d1_valid && sidx[1] < 200 && $urandom % 10 < 7) begin
        d1_valid = 1'b1; d1_data = src[1][sidx[1]];
      end
      o_ready = ($urandom % 10) >= 4;
      @(negedge clk);
      hs0 = d0_valid && d0_ready;
      hs1 = d1_valid && d1_ready;
      ohs = o_valid && o_ready;
      cur = o_data;
      if (prev_stall) begin
        check("stall valid", 32'(o_valid), 32'h1);
        check("stall data", 32'(o_data), 32'(prev_data));
      end
      prev_stall = o_valid && !o_ready;
      prev_data  = o_data;
      if (ohs) begin
        ch = int'(cur[16]);
        if (ridx[ch] < 200) begin
          check($sformatf("ch%0d item%0d", ch, ridx[ch]), 32'({cur[17], cur[15:0]}),
                32'(src[ch][ridx[ch]]));
        end else begin
          n_tests++; n_fail++;
          $display("FAIL ch%0d extra item: got %0h, expected none", ch, cur);
        end
        ridx[ch]++;
        if (in_txn) check("contiguous txn", 32'(cur[16]), 32'(txn_ch));
        in_txn = !cur[17];
        txn_ch = cur[16];
      end
      @(posedge clk); #1;
      if (hs0) begin sidx[0]++; d0_valid = 1'b0; end
      if (hs1) begin sidx[1]++; d1_valid = 1'b0; end
      cyc++;
    end
    check("random ch0 count", 32'(ridx[0]), 32'd200);
    check("random ch1 count", 32'(ridx[1]), 32'd200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
